// File: rtl/mips_pkg.sv
// Shared mipsel32 pipeline definitions: reset vector, fetch FSM encodings and the
// bubble instruction word.
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory req/addr_ok/data_ok channel and the
// valid/allow channel into the IF/ID register. master = fetch side, slave = environment.
interface fetch_stage_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        allow_out;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        exc_adel;

    modport master (
        output inst_req, inst_addr, valid_out, pc_out, inst_out, exc_adel,
        input  inst_addr_ok, inst_data_ok, inst_rdata, allow_out
    );

    modport slave (
        input  inst_req, inst_addr, valid_out, pc_out, inst_out, exc_adel,
        output inst_addr_ok, inst_data_ok, inst_rdata, allow_out
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// Fetch PC register: redirect (flush over branch) has priority over the sequential +4 step.
module fetch_pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR
)
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_flush,
    input  logic [31:0] i_flush_target,
    input  logic        i_br_taken,
    input  logic [31:0] i_br_target,
    input  logic        i_inc,
    output logic        o_redirect,
    output logic [31:0] o_pc
);

    logic [31:0] r_pc;
    logic [31:0] w_target;
    logic        w_redirect;

    assign w_redirect = i_flush | i_br_taken;
    assign w_target   = i_flush ? i_flush_target : i_br_target;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pc <= RESET_PC;
        end else if (w_redirect) begin
            r_pc <= w_target;
        end else if (i_inc) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    assign o_redirect = w_redirect;
    assign o_pc       = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// mipsel32 instruction-fetch stage: one outstanding memory request, held result handed to IF/ID.
// Optional FETCH_ADEL_EN: misaligned PCs skip memory and present an address-error bubble.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR
)
(
    input  logic          clk,
    input  logic          resetn,
    input  logic          br_taken,
    input  logic [31:0]   br_target,
    input  logic          flush,
    input  logic [31:0]   flush_target,
    fetch_stage_if.master bus
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic         r_cancel;
    logic         w_cancel_nxt;
    logic [31:0]  r_inst_buf;
    logic         w_buf_ld;
    logic         w_buf_nop;
    logic         w_pc_inc;
    logic         w_redirect;
    logic         w_issue;
    logic         w_valid;
    logic [31:0]  w_pc;

    fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk            (clk),
        .resetn         (resetn),
        .i_flush        (flush),
        .i_flush_target (flush_target),
        .i_br_taken     (br_taken),
        .i_br_target    (br_target),
        .i_inc          (w_pc_inc),
        .o_redirect     (w_redirect),
        .o_pc           (w_pc)
    );

`ifdef FETCH_ADEL_EN
    logic w_misalign;
    assign w_misalign = |w_pc[1:0];
    assign w_issue    = (r_state == FS_REQ) & ~w_misalign;
`else
    assign w_issue    = (r_state == FS_REQ);
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_cancel_nxt = r_cancel;
        w_buf_ld     = 1'b0;
        w_buf_nop    = 1'b0;
        w_pc_inc     = 1'b0;
        case (r_state)
            FS_REQ: begin
                if (w_issue) begin
                    if (bus.inst_addr_ok) begin
                        w_state_nxt  = FS_WAIT;
                        w_cancel_nxt = w_redirect;
                    end
                end else if (!w_redirect) begin
                    // Unissuable (misaligned) PC: park a bubble in HOLD instead of fetching.
                    w_state_nxt = FS_HOLD;
                    w_buf_ld    = 1'b1;
                    w_buf_nop   = 1'b1;
                end
            end
            FS_WAIT: begin
                if (bus.inst_data_ok) begin
                    w_cancel_nxt = 1'b0;
                    if (r_cancel | w_redirect) begin
                        w_state_nxt = FS_REQ;
                    end else begin
                        w_state_nxt = FS_HOLD;
                        w_buf_ld    = 1'b1;
                    end
                end else if (w_redirect) begin
                    w_cancel_nxt = 1'b1;
                end
            end
            FS_HOLD: begin
                if (w_redirect) begin
                    w_state_nxt = FS_REQ;
                end else if (bus.allow_out) begin
                    w_state_nxt = FS_REQ;
                    w_pc_inc    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = FS_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= FS_REQ;
            r_cancel   <= 1'b0;
            r_inst_buf <= INST_NOP;
        end else begin
            r_state  <= w_state_nxt;
            r_cancel <= w_cancel_nxt;
            if (w_buf_ld) begin
                r_inst_buf <= w_buf_nop ? INST_NOP : bus.inst_rdata;
            end
        end
    end

    // A redirect kills the held instruction in the same cycle, so valid_out sees it directly.
    assign w_valid       = resetn & (r_state == FS_HOLD) & ~w_redirect;
    assign bus.inst_req  = resetn & w_issue;
    assign bus.inst_addr = w_pc;
    assign bus.valid_out = w_valid;
    assign bus.pc_out    = w_pc;
    assign bus.inst_out  = r_inst_buf;

`ifdef FETCH_ADEL_EN
    assign bus.exc_adel  = w_valid & w_misalign;
`else
    assign bus.exc_adel  = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised bench for fetch_stage: transaction-level PC/outstanding/held model plus directed scenarios.
module tb_fetch_stage;
    import mips_pkg::*;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        br_taken = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic [31:0] flush_target = 32'h0;

    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .flush        (flush),
        .flush_target (flush_target),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // stimulus knobs (percent, reset in per-mille)
    int k_aok = 100, k_lat_lo = 0, k_lat_hi = 0, k_allow = 100, k_redir = 0, k_spur = 0, k_rst = 0;
    logic        o_br = 1'b0, o_fl = 1'b0, o_rst = 1'b0;
    logic [31:0] o_bt = 32'h0, o_ft = 32'h0;

    // reference model: architectural PC, the single outstanding request, the held instruction
    logic [31:0] m_pc = RST_PC;
    logic        m_out = 1'b0, m_stale = 1'b0, m_held = 1'b0, m_adel = 1'b0;

    // memory responder (keeps a late response across a DUT reset)
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_lat = 0;

    logic        c_req, c_valid, c_adel;
    logic [31:0] c_addr, c_pc, c_inst;
    logic [31:0] acc_q[$];
    logic [31:0] hand_pc_q[$];
    logic [31:0] hand_inst_q[$];

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C1D_A5E7;
    endfunction

    function automatic logic roll(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    function automatic logic adel_mis(input logic [31:0] pc);
`ifdef FETCH_ADEL_EN
        return |pc[1:0];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_DEAD;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic step();
        logic        s_rstn, s_br, s_fl, s_aok, s_dok, s_allow, redir, exp_req, exp_valid;
        logic [31:0] s_bt, s_ft, s_rdata, tgt;
        @(negedge clk);
        s_rstn = !(o_rst || (int'($urandom_range(999)) < k_rst));
        o_rst  = 1'b0;
        if (o_br || o_fl) begin
            s_br = o_br; s_fl = o_fl; s_bt = o_bt; s_ft = o_ft;
            o_br = 1'b0; o_fl = 1'b0;
        end else begin
            s_br = roll(k_redir);
            s_fl = roll(k_redir / 2);
            s_bt = $urandom() & 32'hFFFF_FFFC;
            s_ft = $urandom() & 32'hFFFF_FFFC;
        end
        exp_req = s_rstn && !m_out && !m_held && !adel_mis(m_pc);
        s_aok   = exp_req && !mem_busy && roll(k_aok);
        if (mem_busy) begin
            s_dok   = (mem_lat == 0);
            s_rdata = mem_f(mem_addr);
        end else begin
            s_dok   = roll(k_spur);
            s_rdata = $urandom();
        end
        s_allow = roll(k_allow);
        resetn = s_rstn; br_taken = s_br; br_target = s_bt; flush = s_fl; flush_target = s_ft;
        bus.inst_addr_ok = s_aok; bus.inst_data_ok = s_dok; bus.inst_rdata = s_rdata;
        bus.allow_out = s_allow;
        #1;
        redir     = s_br | s_fl;
        tgt       = s_fl ? s_ft : s_bt;
        exp_valid = s_rstn && m_held && !redir;
        c_req = bus.inst_req; c_addr = bus.inst_addr; c_valid = bus.valid_out;
        c_pc = bus.pc_out; c_inst = bus.inst_out; c_adel = bus.exc_adel;
        chk1("inst_req", c_req, exp_req);
        if (exp_req) chk("inst_addr", c_addr, m_pc);
        chk1("valid_out", c_valid, exp_valid);
        chk1("exc_adel", c_adel, exp_valid && m_adel);
        if (exp_valid) begin
            chk("pc_out", c_pc, m_pc);
            chk("inst_out", c_inst, m_adel ? 32'h0 : mem_f(m_pc));
        end
        if (s_aok) acc_q.push_back(c_addr);
        if (c_valid && s_allow) begin
            hand_pc_q.push_back(c_pc);
            hand_inst_q.push_back(c_inst);
        end
        @(posedge clk);
        if (s_aok) begin
            mem_busy = 1'b1;
            mem_addr = c_addr;
            mem_lat  = int'($urandom_range(k_lat_hi, k_lat_lo));
        end else if (mem_busy) begin
            if (mem_lat == 0) mem_busy = 1'b0;
            else mem_lat--;
        end
        if (!s_rstn) begin
            m_pc = RST_PC; m_out = 1'b0; m_stale = 1'b0; m_held = 1'b0; m_adel = 1'b0;
        end else if (m_held) begin
            if (redir) begin
                m_held = 1'b0; m_pc = tgt;
            end else if (s_allow) begin
                m_held = 1'b0; m_pc = m_pc + 32'd4;
            end
        end else if (m_out) begin
            if (s_dok) begin
                m_out = 1'b0;
                if (!(m_stale || redir)) begin
                    m_held = 1'b1; m_adel = 1'b0;
                end
            end else if (redir) begin
                m_stale = 1'b1;
            end
            if (redir) m_pc = tgt;
        end else begin
            if (adel_mis(m_pc) && !redir) begin
                m_held = 1'b1; m_adel = 1'b1;
            end else if (s_aok) begin
                m_out = 1'b1; m_stale = redir;
            end
            if (redir) m_pc = tgt;
        end
    endtask

    // what: 0 = instruction held, 1 = live (non-cancelled) request outstanding
    task automatic run_until(input int what, input string nm);
        int n = 0;
        while (!((what == 0) ? m_held : (m_out && !m_stale)) && n < 60) begin
            step();
            n++;
        end
        checks++;
        if (n >= 60) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d required<60", nm, n);
        end
    endtask

    initial begin
        int n0, a0;
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'h0; bus.allow_out = 1'b0;

        repeat (3) begin o_rst = 1'b1; step(); end

        // sequential fetch, zero-wait memory, downstream always ready
        repeat (10) step();
        chkn("t1_acc_count", acc_q.size(), 4);
        chk("t1_acc0", qget(acc_q, 0), 32'hBFC0_0000);
        chk("t1_acc1", qget(acc_q, 1), 32'hBFC0_0004);
        chk("t1_acc2", qget(acc_q, 2), 32'hBFC0_0008);
        chkn("t1_hand_count", hand_pc_q.size(), 3);
        chk("t1_hand_pc0", qget(hand_pc_q, 0), 32'hBFC0_0000);
        chk("t1_hand_pc2", qget(hand_pc_q, 2), 32'hBFC0_0008);
        chk("t1_hand_inst0", qget(hand_inst_q, 0), 32'h3C1D_1A27);

        // back-pressure in HOLD
        k_allow = 0;
        run_until(0, "t2_hold");
        repeat (5) step();
        chk("t2_pc_stable", c_pc, 32'hBFC0_000C);
        chk1("t2_valid_stable", c_valid, 1'b1);
        chk1("t2_no_req", c_req, 1'b0);
        chkn("t2_no_handoff", hand_pc_q.size(), 3);
        k_allow = 100;
        step();
        chkn("t2_handoff", hand_pc_q.size(), 4);

        // branch while waiting for data: response discarded
        k_lat_lo = 2; k_lat_hi = 2;
        run_until(1, "t3_wait");
        n0 = hand_pc_q.size();
        a0 = acc_q.size();
        o_br = 1'b1; o_bt = 32'h8000_1000;
        step();
        run_until(0, "t3_refetch");
        chk("t3_next_req", qget(acc_q, a0), 32'h8000_1000);
        chkn("t3_no_discarded", hand_pc_q.size(), n0);
        step();
        chk("t3_hand_pc", qget(hand_pc_q, n0), 32'h8000_1000);
        chk("t3_hand_inst", qget(hand_inst_q, n0), 32'h2C1D_25E7);

        // flush and branch together in HOLD: flush wins, valid dropped
        k_allow = 0;
        run_until(0, "t4_hold");
        o_br = 1'b1; o_bt = 32'h8000_2000; o_fl = 1'b1; o_ft = 32'hBFC0_0380;
        step();
        chk1("t4_valid_drop", c_valid, 1'b0);
        step();
        chk1("t4_req", c_req, 1'b1);
        chk("t4_addr", c_addr, 32'hBFC0_0380);

        // misaligned branch target
        run_until(0, "t5_hold");
        o_br = 1'b1; o_bt = 32'h8000_0002;
        step();
        step();
`ifdef FETCH_ADEL_EN
        chk1("t5_no_req", c_req, 1'b0);
        step();
        chk1("t5_valid", c_valid, 1'b1);
        chk1("t5_adel", c_adel, 1'b1);
        chk("t5_pc", c_pc, 32'h8000_0002);
        chk("t5_inst", c_inst, 32'h0);
`else
        chk1("t5_req", c_req, 1'b1);
        chk("t5_addr", c_addr, 32'h8000_0002);
        run_until(0, "t5_hold2");
        step();
        chk1("t5_adel_tied", c_adel, 1'b0);
        chk("t5_pc", c_pc, 32'h8000_0002);
`endif
        o_br = 1'b1; o_bt = 32'h8000_0100;
        k_allow = 100;
        step();

        // one-cycle reset while a request is outstanding
        k_lat_lo = 3; k_lat_hi = 3;
        run_until(1, "t6_wait");
        o_rst = 1'b1;
        step();
        chk1("t6_req_in_reset", c_req, 1'b0);
        step();
        chk1("t6_req", c_req, 1'b1);
        chk("t6_addr", c_addr, 32'hBFC0_0000);
        n0 = hand_pc_q.size();
        run_until(0, "t6_hold");
        step();
        chk("t6_hand_pc", qget(hand_pc_q, n0), 32'hBFC0_0000);
        chk("t6_hand_inst", qget(hand_inst_q, n0), 32'h3C1D_1A27);

        // randomised traffic
        k_aok = 60; k_lat_lo = 0; k_lat_hi = 3; k_allow = 70; k_redir = 4; k_spur = 10; k_rst = 3;
        n0 = hand_pc_q.size();
        repeat (3000) step();
        chk1("rand_progress", hand_pc_q.size() > n0 + 50, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the mipsel32 pipeline. Holds the PC, issues one instruction-memory request at a time over a req/addr_ok/data_ok handshake, and presents each fetched instruction with its PC to the IF/ID pipeline register through a valid/allow handshake. Branch redirects and exception flushes retarget the PC and cancel in-flight or held fetches.

## Interface

- `RESET_PC`, default 32'hBFC0_0000: PC after reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `br_taken`  in  1  branch redirect, one-cycle pulse from decode.
- `br_target`  in  32  branch target, valid with `br_taken`.
- `flush`  in  1  exception/eret redirect; overrides `br_taken`.
- `flush_target`  in  32  flush target, valid with `flush`.
- `inst_req`  out  1  memory request valid.
- `inst_addr`  out  32  request address.
- `inst_addr_ok`  in  1  request accepted this cycle.
- `inst_data_ok`  in  1  response valid this cycle.
- `inst_rdata`  in  32  response data.
- `allow_out`  in  1  downstream register can accept.
- `valid_out`  out  1  `pc_out`/`inst_out` valid.
- `pc_out`  out  32  PC of the presented instruction.
- `inst_out`  out  32  presented instruction word.
- `exc_adel`  out  1  fetch address error on the presented instruction.

## Operation

- Redirect = `flush | br_taken`. Target = `flush_target` if `flush`, else `br_target`.
- State REQ:
  - `inst_req`=1, `inst_addr`=`pc`.
  - `inst_addr_ok` -> WAIT.
  - Redirect without `inst_addr_ok`: `pc`<=target, stay in REQ.
  - Redirect with `inst_addr_ok`: `pc`<=target, `cancel`<=1, -> WAIT.
- State WAIT:
  - `inst_req`=0.
  - Redirect: `pc`<=target, `cancel`<=1.
  - `inst_data_ok` with (`cancel` or redirect): discard the data, `cancel`<=0, -> REQ.
  - `inst_data_ok` otherwise: `inst_buf`<=`inst_rdata`, -> HOLD.
- State HOLD:
  - `valid_out` = ~redirect. `pc_out`=`pc`, `inst_out`=`inst_buf`.
  - Redirect: drop the held instruction, `pc`<=target, -> REQ.
  - `allow_out` without redirect: handoff, `pc`<=`pc`+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0), -> REQ.
  - Otherwise hold all outputs stable.
- `inst_data_ok` in REQ or HOLD (stale response after reset) is ignored.
- At most one outstanding request.

## Timing

- Reset (`resetn`=0 at an edge):
  - State: REQ, `pc`=`RESET_PC`, `cancel`=0, `inst_buf`=0.
  - While `resetn`=0: `inst_req`=0, `valid_out`=0, `exc_adel`=0.
  - A reset in mid-operation abandons any outstanding request.
- First `inst_req`=1 in the first cycle with `resetn`=1.
- `valid_out` rises the cycle after the accepted `inst_data_ok`. With zero-wait memory this gives 3 cycles per instruction.
- `inst_addr` is stable while `inst_req`=1, except on a redirect.
- `valid_out` is combinational in redirect only; all other outputs are registered.

## Configuration

- `FETCH_ADEL_EN` defined:
  - In REQ with `pc[1:0]`!=0: no request is issued (`inst_req`=0) and the block goes to HOLD next cycle.
  - In HOLD: `inst_out`=0, `exc_adel`=1 while `valid_out`.
  - Redirect and handoff rules are unchanged.
- Not defined:
  - `exc_adel` is tied 0.
  - The PC is issued unmodified regardless of alignment.

## Structure

- Shared package `mips_pkg`:
  - `RESET_VECTOR` (32'hBFC0_0000).
  - Fetch state encodings (REQ, WAIT, HOLD).
  - `INST_NOP` (32'h0).
- Sub-module `fetch_pc_reg`: the PC register, redirect priority mux, and +4 incrementer. It takes the state-machine update enables as inputs.

## Test plan

- Reset release, memory with `inst_addr_ok` and `inst_data_ok` one cycle apart, `allow_out`=1 -> requests 0xBFC00000, 0xBFC00004, 0xBFC00008 in order. `valid_out` pulses carry the matching PCs and data.
- `allow_out`=0 for 5 cycles in HOLD -> `valid_out`, `pc_out`, `inst_out` stable and no new request. Handoff on the first `allow_out`=1.
- `br_taken` with `br_target`=0x80001000 in WAIT -> the next response is discarded. The next request is 0x80001000 and `valid_out` never shows the discarded word.
- `flush` and `br_taken` in the same cycle in HOLD (targets 0xBFC00380 and 0x80002000) -> `valid_out`=0 that cycle, next `inst_addr`=0xBFC00380.
- `FETCH_ADEL_EN`, `br_target`=0x80000002 -> no `inst_req`. `valid_out` with `exc_adel`=1, `pc_out`=0x80000002, `inst_out`=0.
- `resetn`=0 for one cycle while in WAIT -> `inst_req`=0 that cycle. The next cycle requests 0xBFC00000, and a late `inst_data_ok` is ignored.
